clk_en_select: RTL and testbench

CLK_EN_SELECT -- requirements
Module: clk_en_select

---
 rtl/clk_en_select_pkg.sv | 12 +
 rtl/clk_en_div.sv | 53 +++++
 rtl/clk_en_select.sv | 87 ++++++++
 tb/tb_clk_en_select.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/clk_en_select_pkg.sv
// clk_en_select_pkg: shared state encoding, ratio width default and width helper
// Contents: state_t (RUN/DRAIN/GAP/LOAD), DIV_W_DEF, clog2()
package clk_en_select_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_GAP, ST_LOAD} state_t;
    localparam int DIV_W_DEF = 8;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: period counter, ratio latch and registered clk_en/clk_div generation
// Ports: i_clk, i_rst (sync, active-high), i_run (count and drive outputs),
//        i_load (restart at cnt 0 with i_ratio), i_ratio (ratio of the selected channel),
//        o_last (cnt is at R-1 this cycle), o_clk_en, o_clk_div (registered outputs)
module clk_en_div
    import clk_en_select_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_ratio,
    output logic             o_last,
    output logic             o_clk_en,
    output logic             o_clk_div
);
    logic [DIV_W-1:0] r_cnt, r_ratio, w_norm, w_r, w_half;
    logic r_fresh, r_en, r_div, w_last;
    assign w_norm = (i_ratio == '0) ? DIV_W'(1) : i_ratio;
    // right after reset nothing has been latched yet, so the live ratio is used for that first cycle
    assign w_r = r_fresh ? w_norm : r_ratio;
    assign w_half = (w_r >> 1) + {{(DIV_W-1){1'b0}}, w_r[0]};
    assign w_last = r_cnt == w_r - DIV_W'(1);
    assign o_last = w_last;
    assign o_clk_en = r_en;
    assign o_clk_div = r_div;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_ratio <= DIV_W'(1);
            r_fresh <= 1'b1;
            r_en    <= 1'b0;
            r_div   <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= '0;
            r_ratio <= w_norm;
            r_fresh <= 1'b0;
            r_en    <= 1'b0;
            r_div   <= 1'b0;
        end else if (i_run) begin
            r_cnt   <= w_last ? '0 : r_cnt + DIV_W'(1);
            r_ratio <= w_last ? w_norm : w_r;
            r_fresh <= 1'b0;
            r_en    <= w_last;
            r_div   <= r_cnt < w_half;
        end else begin
            r_en    <= 1'b0;
            r_div   <= 1'b0;
        end
    end
endmodule

// File: rtl/clk_en_select.sv
// clk_en_select: glitch-free switch between divided clock-enable channels
// Ports: clk_i, rst_i (sync, active-high), cfg_div_i (per-channel ratio, channel k at [k*DIV_W +: DIV_W]),
//        sel_i / sel_valid_i / sel_ready_o (switch request handshake), clk_en_o (one pulse per period),
//        clk_div_o (divided square wave), active_sel_o, switching_o, sel_err_o (rejected request pulse)
// Build option: CLK_EN_SELECT_DEAD_GAP_EN inserts DEAD_CYC idle cycles between the old and new channel.
module clk_en_select
    import clk_en_select_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEAD_CYC    = 2,
    parameter int DEFAULT_SEL = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_CH*DIV_W-1:0]   cfg_div_i,
    input  logic [clog2(NUM_CH)-1:0]  sel_i,
    input  logic                      sel_valid_i,
    output logic                      sel_ready_o,
    output logic                      clk_en_o,
    output logic                      clk_div_o,
    output logic [clog2(NUM_CH)-1:0]  active_sel_o,
    output logic                      switching_o,
    output logic                      sel_err_o
);
    localparam int SEL_W = clog2(NUM_CH);
    state_t r_state, w_next;
    logic [SEL_W-1:0] r_active, r_pend, w_ch;
    logic [DIV_W-1:0] w_ratio;
    logic [3:0] r_gap;
    logic r_err, w_acc, w_bad, w_last, w_run, w_load, w_gap_done;
    assign w_acc = sel_valid_i && (r_state == ST_RUN);
    assign w_bad = int'(sel_i) >= NUM_CH;
    assign w_gap_done = r_gap == 4'(DEAD_CYC - 1);
    // LOAD latches the ratio of the channel being switched to, otherwise the active one
    assign w_ch = (r_state == ST_LOAD) ? r_pend : r_active;
    assign w_ratio = cfg_div_i[int'(w_ch)*DIV_W +: DIV_W];
    assign active_sel_o = r_active;
    assign sel_err_o = r_err;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_RUN;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:   w_next = (w_acc && !w_bad && sel_i != r_active) ? ST_DRAIN : ST_RUN;
`ifdef CLK_EN_SELECT_DEAD_GAP_EN
            ST_DRAIN: w_next = w_last ? ST_GAP : ST_DRAIN;
`else
            ST_DRAIN: w_next = w_last ? ST_LOAD : ST_DRAIN;
`endif
            ST_GAP:   w_next = w_gap_done ? ST_LOAD : ST_GAP;
            ST_LOAD:  w_next = ST_RUN;
            default:  w_next = ST_RUN;
        endcase
    end
    always_comb begin
        w_run       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_load      = r_state == ST_LOAD;
        sel_ready_o = r_state == ST_RUN;
        switching_o = r_state != ST_RUN;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active <= SEL_W'(DEFAULT_SEL);
            r_pend   <= SEL_W'(DEFAULT_SEL);
            r_gap    <= 4'd0;
            r_err    <= 1'b0;
        end else begin
            r_active <= w_load ? r_pend : r_active;
            r_pend   <= (r_state == ST_RUN && w_next == ST_DRAIN) ? sel_i : r_pend;
            r_gap    <= (r_state == ST_GAP) ? r_gap + 4'd1 : 4'd0;
            r_err    <= w_acc && w_bad;
        end
    end
    clk_en_div #(.DIV_W(DIV_W)) u_div (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_run     (w_run),
        .i_load    (w_load),
        .i_ratio   (w_ratio),
        .o_last    (w_last),
        .o_clk_en  (clk_en_o),
        .o_clk_div (clk_div_o)
    );
endmodule

// File: tb/tb_clk_en_select.sv
// tb_clk_en_select: randomized self-checking bench with a queue-based output schedule model
module tb_clk_en_select;
    localparam int NCH = 6, DW = 8, DEAD = 2, DEF = 0;
    logic clk_i = 1'b0, rst_i = 1'b1, sel_valid_i = 1'b0;
    logic [NCH*DW-1:0] cfg_div_i = '0;
    logic [2:0] sel_i = 3'd0;
    logic sel_ready_o, clk_en_o, clk_div_o, switching_o, sel_err_o;
    logic [2:0] active_sel_o;
    int n_chk = 0, n_pass = 0;
    typedef struct packed {logic en; logic div; logic last; logic load;} ent_t;
    ent_t q[$];
    int m_active = DEF, m_pend = DEF;
    logic m_busy = 1'b0, m_err = 1'b0, exp_en = 1'b0, exp_div = 1'b0;
    clk_en_select #(.NUM_CH(NCH), .DIV_W(DW), .DEAD_CYC(DEAD), .DEFAULT_SEL(DEF)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_div_i(cfg_div_i), .sel_i(sel_i),
        .sel_valid_i(sel_valid_i), .sel_ready_o(sel_ready_o), .clk_en_o(clk_en_o),
        .clk_div_o(clk_div_o), .active_sel_o(active_sel_o), .switching_o(switching_o),
        .sel_err_o(sel_err_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask
    // queue one full period of channel ch as seen on the outputs, using the ratio present now
    task automatic push_period(input int ch);
        int r;
        r = int'(cfg_div_i[ch*DW +: DW]);
        if (r == 0) r = 1;
        for (int c = 0; c < r; c++) q.push_back(ent_t'{c == r-1, c < (r+1)/2, c == r-1, 1'b0});
    endtask
    // advance the model by one cycle with the inputs currently applied
    task automatic model_step();
        ent_t e;
        logic nb;
        if (rst_i) begin
            q.delete();
            m_active = DEF; m_pend = DEF; m_busy = 1'b0; m_err = 1'b0; exp_en = 1'b0; exp_div = 1'b0;
            return;
        end
        if (q.size() == 0) push_period(m_active);
        e = q.pop_front();
        exp_en = e.en; exp_div = e.div; nb = m_busy; m_err = 1'b0;
        if (e.load) begin
            m_active = m_pend;
            push_period(m_active);
            nb = 1'b0;
        end else if (e.last && m_busy) begin
`ifdef CLK_EN_SELECT_DEAD_GAP_EN
            repeat (DEAD) q.push_back(ent_t'(4'b0000));
`endif
            q.push_back(ent_t'(4'b0001));
        end else if (e.last) push_period(m_active);
        if (!m_busy && sel_valid_i) begin
            if (int'(sel_i) >= NCH) m_err = 1'b1;
            else if (int'(sel_i) != m_active) begin
                m_pend = int'(sel_i);
                nb = 1'b1;
            end
        end
        m_busy = nb;
    endtask
    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        chk("clk_en", clk_en_o, exp_en);
        chk("clk_div", clk_div_o, exp_div);
        chk("active_sel", active_sel_o, m_active);
        chk("switching", switching_o, m_busy);
        chk("sel_ready", sel_ready_o, !m_busy);
        chk("sel_err", sel_err_o, m_err);
    endtask
    initial begin
        int init_r[NCH] = '{3, 4, 5, 6, 2, 1};
        int n;
        logic seen;
        for (int k = 0; k < NCH; k++) cfg_div_i[k*DW +: DW] = 8'(init_r[k]);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        repeat (9) tick();
        tick();
        cfg_div_i[0 +: DW] = 8'd7;
        repeat (16) tick();
        cfg_div_i[0 +: DW] = 8'd3;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sel_valid_i = 1'b1; sel_i = 3'd2;
        tick();
        sel_valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && switching_o; i++) begin
            n++;
            tick();
        end
`ifdef CLK_EN_SELECT_DEAD_GAP_EN
        chk("switch_len", n, 5);
`else
        chk("switch_len", n, 3);
`endif
        repeat (12) tick();
        sel_valid_i = 1'b1; sel_i = 3'd6;
        tick();
        sel_valid_i = 1'b0;
        chk("err_pulse", sel_err_o, 1);
        chk("err_keep_sel", active_sel_o, 2);
        tick();
        chk("err_one_cycle", sel_err_o, 0);
        repeat (4) tick();
        sel_valid_i = 1'b1; sel_i = 3'd1;
        tick();
        sel_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = clk_en_o && switching_o;
        end
        chk("drain_seen", seen, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_clk_en", clk_en_o, 0);
        chk("rst_clk_div", clk_div_o, 0);
        chk("rst_active", active_sel_o, DEF);
        chk("rst_switching", switching_o, 0);
        chk("rst_ready", sel_ready_o, 1);
        chk("rst_err", sel_err_o, 0);
        for (int i = 0; i < 3000; i++) begin
            int k;
            rst_i = ($urandom_range(0, 199) == 0);
            sel_valid_i = ($urandom_range(0, 3) == 0);
            sel_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                k = int'($urandom_range(0, NCH-1));
                cfg_div_i[k*DW +: DW] = 8'($urandom_range(0, 7));
            end
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
